// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: handshake bundle between a producer/consumer pair and
// one sync_fifo_flags queue.
//   master : drives flush, wr_en, data_in, rd_en; observes data and status
//   slave  : the FIFO itself
// Parameters must match the ones given to the connected sync_fifo_flags.
interface sync_fifo_flags_if #(
  parameter int W_WIDTH   = 8,
  parameter int FIFO_SIZE = 64
);
  localparam int LW = $clog2(FIFO_SIZE + 1);

  logic               flush;
  logic               wr_en;
  logic [W_WIDTH-1:0] data_in;
  logic               rd_en;
  logic [W_WIDTH-1:0] data_out;
  logic               rd_valid;
  logic               empty;
  logic               full;
  logic               almost_empty;
  logic               almost_full;
  logic [LW-1:0]      level;
  logic               overflow;
  logic               underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, rd_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parametrised per-output-queue FIFO with occupancy count,
// threshold flags, sticky overflow/underflow errors and synchronous flush.
// Optional first-word-fall-through read mode (FWFT=1).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high
//   bus  - sync_fifo_flags_if.slave: flush, wr_en, data_in, rd_en in;
//          data_out, rd_valid, empty, full, almost_empty, almost_full,
//          level, overflow, underflow out
module sync_fifo_flags #(
  parameter int W_WIDTH   = 8,
  parameter int FIFO_SIZE = 64,
  parameter int AF_THRESH = FIFO_SIZE - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_flags_if.slave bus
);

  localparam int LW = $clog2(FIFO_SIZE + 1);
  localparam int PW = $clog2(FIFO_SIZE);

  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_SIZE);
  localparam logic [LW-1:0] AF_LVL   = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_SIZE - 1);

  // Elaboration-time parameter legality.
  if (W_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: W_WIDTH must be >= 1");
  end
  if (FIFO_SIZE < 2) begin : g_bad_size
    $error("sync_fifo_flags: FIFO_SIZE must be >= 2");
  end
  if (AF_THRESH < 0 || AF_THRESH > FIFO_SIZE) begin : g_bad_af
    $error("sync_fifo_flags: AF_THRESH outside 0..FIFO_SIZE");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_SIZE) begin : g_bad_ae
    $error("sync_fifo_flags: AE_THRESH outside 0..FIFO_SIZE");
  end

  logic [W_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [LW-1:0]      level_q;
  logic               overflow_q;
  logic               underflow_q;

  logic empty_w;
  logic full_w;
  logic rd_acc;
  logic wr_acc;

  // Explicit wrap so any depth works, not only powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == FULL_LVL);

  // A pop frees the slot this edge, so a full FIFO still takes a write.
  assign rd_acc = bus.rd_en && !empty_w;
  assign wr_acc = bus.wr_en && (!full_w || rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (bus.wr_en && !wr_acc) overflow_q  <= 1'b1;
      if (bus.rd_en && empty_w) underflow_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  if (FWFT == 0) begin : g_std_read
    logic [W_WIDTH-1:0] dout_q;
    logic               rvalid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q   <= '0;
        rvalid_q <= 1'b0;
      end else if (bus.flush) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign bus.data_out = dout_q;
    assign bus.rd_valid = rvalid_q;
  end else begin : g_fwft_read
    // Head word is shown directly; masked to zero while empty so stale
    // storage never leaks out after reset or flush.
    assign bus.data_out = empty_w ? '0 : mem[rd_ptr];
    assign bus.rd_valid = !empty_w;
  end

  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (level_q <= AE_LVL);
  assign bus.almost_full  = (level_q >= AF_LVL);
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // a: depth 8 standard, AF=6 AE=2 ; b: depth 6 standard ; c: depth 8 FWFT
  sync_fifo_flags_if #(.W_WIDTH(8), .FIFO_SIZE(8)) bus_a ();
  sync_fifo_flags_if #(.W_WIDTH(8), .FIFO_SIZE(6)) bus_b ();
  sync_fifo_flags_if #(.W_WIDTH(8), .FIFO_SIZE(8)) bus_c ();

  sync_fifo_flags #(.W_WIDTH(8), .FIFO_SIZE(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0))
    u_std (.clk(clk), .rst(rst), .bus(bus_a));
  sync_fifo_flags #(.W_WIDTH(8), .FIFO_SIZE(6), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0))
    u_odd (.clk(clk), .rst(rst), .bus(bus_b));
  sync_fifo_flags #(.W_WIDTH(8), .FIFO_SIZE(8), .AF_THRESH(4), .AE_THRESH(4), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .bus(bus_c));

  // {level, empty, full, almost_empty, almost_full, overflow, underflow, rd_valid, data_out}
  localparam logic [18:0] RST_A = {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
  localparam logic [17:0] RST_B = {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
  localparam logic [18:0] RST_C = {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

  function automatic logic [18:0] stat_a();
    return {bus_a.level, bus_a.empty, bus_a.full, bus_a.almost_empty, bus_a.almost_full,
            bus_a.overflow, bus_a.underflow, bus_a.rd_valid, bus_a.data_out};
  endfunction
  function automatic logic [17:0] stat_b();
    return {bus_b.level, bus_b.empty, bus_b.full, bus_b.almost_empty, bus_b.almost_full,
            bus_b.overflow, bus_b.underflow, bus_b.rd_valid, bus_b.data_out};
  endfunction
  function automatic logic [18:0] stat_c();
    return {bus_c.level, bus_c.empty, bus_c.full, bus_c.almost_empty, bus_c.almost_full,
            bus_c.overflow, bus_c.underflow, bus_c.rd_valid, bus_c.data_out};
  endfunction

  // Reference contents (mdl_*) and popped words awaiting rd_valid (exp_*).
  logic [7:0] mdl_a[$], exp_a[$], mdl_b[$], exp_b[$], mdl_c[$];
  logic [7:0] last_a, last_b;

  task automatic cyc_a(input logic w, input logic [7:0] d, input logic r);
    logic racc, wacc;
    logic [7:0] e;
    racc = r && (mdl_a.size() != 0);
    wacc = w && ((mdl_a.size() < 8) || racc);
    if (racc) exp_a.push_back(mdl_a.pop_front());
    if (wacc) mdl_a.push_back(d);
    bus_a.wr_en = w; bus_a.data_in = d; bus_a.rd_en = r;
    @(posedge clk); #1;
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
    checks++;
    if (bus_a.rd_valid !== racc) begin
      errors++; $display("FAIL a_rd_valid: got %b want %b", bus_a.rd_valid, racc);
    end
    if (bus_a.rd_valid === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++; $display("FAIL a_unexpected_word: got %h want none", bus_a.data_out);
      end else begin
        e = exp_a.pop_front();
        last_a = e;
        if (bus_a.data_out !== e) begin
          errors++; $display("FAIL a_data: got %h want %h", bus_a.data_out, e);
        end
      end
    end
  endtask

  task automatic cyc_b(input logic w, input logic [7:0] d, input logic r);
    logic racc, wacc;
    logic [7:0] e;
    racc = r && (mdl_b.size() != 0);
    wacc = w && ((mdl_b.size() < 6) || racc);
    if (racc) exp_b.push_back(mdl_b.pop_front());
    if (wacc) mdl_b.push_back(d);
    bus_b.wr_en = w; bus_b.data_in = d; bus_b.rd_en = r;
    @(posedge clk); #1;
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
    checks++;
    if (bus_b.rd_valid !== racc) begin
      errors++; $display("FAIL b_rd_valid: got %b want %b", bus_b.rd_valid, racc);
    end
    if (bus_b.rd_valid === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++; $display("FAIL b_unexpected_word: got %h want none", bus_b.data_out);
      end else begin
        e = exp_b.pop_front();
        last_b = e;
        if (bus_b.data_out !== e) begin
          errors++; $display("FAIL b_data: got %h want %h", bus_b.data_out, e);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stat_a() !== RST_A) begin errors++; $display("FAIL reset_a: got %h want %h", stat_a(), RST_A); end
    checks++;
    if (stat_b() !== RST_B) begin errors++; $display("FAIL reset_b: got %h want %h", stat_b(), RST_B); end
    checks++;
    if (stat_c() !== RST_C) begin errors++; $display("FAIL reset_c: got %h want %h", stat_c(), RST_C); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1'b1, 8'(i), 1'b0);
      checks++;
      if (bus_a.level !== 4'(i)) begin
        errors++; $display("FAIL fill_level: got %0d want %0d", bus_a.level, i);
      end
      checks++;
      if (bus_a.almost_full !== (i >= 6)) begin
        errors++; $display("FAIL fill_almost_full: got %b want %b at level %0d", bus_a.almost_full, (i >= 6), i);
      end
      checks++;
      if (bus_a.almost_empty !== (i <= 2)) begin
        errors++; $display("FAIL fill_almost_empty: got %b want %b at level %0d", bus_a.almost_empty, (i <= 2), i);
      end
    end
    checks++;
    if (bus_a.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", bus_a.full); end
    cyc_a(1'b1, 8'h09, 1'b0);
    checks++;
    if (bus_a.overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", bus_a.overflow); end
    checks++;
    if (bus_a.level !== 4'd8) begin errors++; $display("FAIL overflow_level: got %0d want 8", bus_a.level); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) cyc_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (last_a !== 8'h08) begin errors++; $display("FAIL drain_last: got %h want 08", last_a); end
    checks++;
    if (bus_a.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", bus_a.empty); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 8; i++) cyc_a(1'b1, 8'(8'h10 + i), 1'b0);
    cyc_a(1'b1, 8'hAA, 1'b1);
    checks++;
    if (bus_a.level !== 4'd8 || bus_a.full !== 1'b1) begin
      errors++; $display("FAIL full_simul: got level %0d full %b want level 8 full 1", bus_a.level, bus_a.full);
    end
    for (int i = 0; i < 8; i++) cyc_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (last_a !== 8'hAA) begin errors++; $display("FAIL full_simul_last: got %h want aa", last_a); end
  endtask

  task automatic test_empty_simul();
    cyc_a(1'b1, 8'h55, 1'b1);
    checks++;
    if (bus_a.level !== 4'd1) begin errors++; $display("FAIL empty_simul_level: got %0d want 1", bus_a.level); end
    checks++;
    if (bus_a.underflow !== 1'b1) begin errors++; $display("FAIL empty_simul_underflow: got %b want 1", bus_a.underflow); end
    cyc_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (last_a !== 8'h55) begin errors++; $display("FAIL empty_simul_read: got %h want 55", last_a); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 8'(8'h60 + i), 1'b0);
    checks++;
    if (bus_a.level !== 4'd5 || bus_a.overflow !== 1'b1) begin
      errors++; $display("FAIL flush_pre: got level %0d ovf %b want level 5 ovf 1", bus_a.level, bus_a.overflow);
    end
    bus_a.flush = 1'b1; bus_a.wr_en = 1'b1; bus_a.data_in = 8'h77;
    @(posedge clk); #1;
    bus_a.flush = 1'b0; bus_a.wr_en = 1'b0;
    mdl_a.delete(); exp_a.delete();
    checks++;
    if (stat_a() !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, last_a}) begin
      errors++; $display("FAIL flush_state: got %h want %h", stat_a(),
                         {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, last_a});
    end
  endtask

  task automatic test_wrap_odd();
    for (int i = 0; i < 3; i++) cyc_b(1'b1, 8'(8'hB0 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc_b(1'b1, 8'(8'hC0 + i), 1'b1);
      checks++;
      if (bus_b.level !== 3'd3) begin errors++; $display("FAIL wrap_level: got %0d want 3", bus_b.level); end
    end
    for (int i = 0; i < 3; i++) cyc_b(1'b0, 8'h00, 1'b1);
    checks++;
    if (last_b !== 8'hD3 || bus_b.empty !== 1'b1) begin
      errors++; $display("FAIL wrap_end: got last %h empty %b want last d3 empty 1", last_b, bus_b.empty);
    end
  endtask

  task automatic test_fwft();
    bus_c.wr_en = 1'b1; bus_c.data_in = 8'h33;
    @(posedge clk); #1;
    bus_c.wr_en = 1'b0;
    checks++;
    if (bus_c.data_out !== 8'h33 || bus_c.rd_valid !== 1'b1) begin
      errors++; $display("FAIL fwft_show: got %h/%b want 33/1", bus_c.data_out, bus_c.rd_valid);
    end
    bus_c.rd_en = 1'b1;
    @(posedge clk); #1;
    bus_c.rd_en = 1'b0;
    checks++;
    if (bus_c.empty !== 1'b1 || bus_c.rd_valid !== 1'b0) begin
      errors++; $display("FAIL fwft_pop_empty: got %b/%b want 1/0", bus_c.empty, bus_c.rd_valid);
    end
    for (int i = 0; i < 3; i++) begin
      bus_c.wr_en = 1'b1; bus_c.data_in = 8'(8'h41 + i);
      mdl_c.push_back(8'(8'h41 + i));
      @(posedge clk); #1;
    end
    bus_c.wr_en = 1'b0;
    while (mdl_c.size() != 0) begin
      checks++;
      if (bus_c.data_out !== mdl_c[0] || bus_c.rd_valid !== 1'b1) begin
        errors++; $display("FAIL fwft_head: got %h/%b want %h/1", bus_c.data_out, bus_c.rd_valid, mdl_c[0]);
      end
      bus_c.rd_en = 1'b1;
      void'(mdl_c.pop_front());
      @(posedge clk); #1;
      bus_c.rd_en = 1'b0;
    end
    checks++;
    if (bus_c.empty !== 1'b1) begin errors++; $display("FAIL fwft_drained: got %b want 1", bus_c.empty); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 8'(8'hE0 + i), 1'b0);
    cyc_a(1'b1, 8'hE3, 1'b1);
    bus_a.wr_en = 1'b1; bus_a.data_in = 8'hE4; bus_a.rd_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (stat_a() !== RST_A) begin errors++; $display("FAIL midburst_reset: got %h want %h", stat_a(), RST_A); end
    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_a.delete(); exp_a.delete();
    cyc_a(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus_a.underflow !== 1'b1 || bus_a.level !== 4'd0) begin
      errors++; $display("FAIL after_reset_read: got udf %b level %0d want 1/0", bus_a.underflow, bus_a.level);
    end
  endtask

  initial begin
    bus_a.flush = 1'b0; bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.data_in = '0;
    bus_b.flush = 1'b0; bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.data_in = '0;
    bus_c.flush = 1'b0; bus_c.wr_en = 1'b0; bus_c.rd_en = 1'b0; bus_c.data_in = '0;
    last_a = '0; last_b = '0;
    test_reset();
    test_fill_overflow();
    test_drain();
    test_full_simul();
    test_empty_simul();
    test_flush();
    test_wrap_odd();
    test_fwft();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the switch's per-port FIFO. Adds configurable depth, width and threshold flags, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. Also offers an optional first-word-fall-through (FWFT) read mode. It sits between the switch ingress parser and the per-port egress arbiters, one instance per output queue.

Parameters:
W_WIDTH, 8, data word width in bits (>=1)
FIFO_SIZE, 64, depth in words (>=2, any integer, not restricted to power of 2)
AF_THRESH, FIFO_SIZE-4, almost_full asserted when level >= AF_THRESH
AE_THRESH, 4, almost_empty asserted when level <= AE_THRESH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous clear of contents and error flags
wr_en  input  1  write request
data_in  input  W_WIDTH  write data
rd_en  input  1  read (pop) request
data_out  output  W_WIDTH  read data
rd_valid  output  1  data_out holds valid popped/head word
empty  output  1  level == 0
full  output  1  level == FIFO_SIZE
almost_empty  output  1  level <= AE_THRESH
almost_full  output  1  level >= AF_THRESH
level  output  $clog2(FIFO_SIZE+1)  current occupancy
overflow  output  1  sticky: write attempted while blocked
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (async, rst=1): pointers=0, level=0, data_out=0, rd_valid=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=0, underflow=0. RAM contents are not reset.
- Flags are derived from a registered level counter. All flags update in the same cycle as level.
- rd_acc = rd_en && !empty. wr_acc = wr_en && (!full || rd_acc). When full, a simultaneous read and write both succeed and level is unchanged.
- When empty, a simultaneous write and read: only the write is accepted; level becomes 1 and underflow is set.
- level += wr_acc - rd_acc each cycle, with no overflow of the counter.
- Pointers wrap from FIFO_SIZE-1 to 0 explicitly (non-power-of-2 safe).
- overflow sets when wr_en && !wr_acc. underflow sets when rd_en && empty. Both hold until flush or rst.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= ram[rd_ptr] at that edge, and rd_valid=1 the following cycle. Read latency is 1 cycle.
  - With no rd_acc, rd_valid=0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = ram[rd_ptr] combinationally and rd_valid = !empty.
  - rd_en acts as acknowledge/pop; the next word is presented in the cycle after the pop.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- flush (synchronous):
  - Pointers, level, overflow and underflow clear to 0; empty=1; rd_valid=0.
  - flush has priority over wr_en/rd_en in the same cycle; both are ignored.
  - data_out is unchanged in standard mode.
- Reset mid-operation: everything returns to reset state immediately. Words in flight are discarded, and nothing is readable afterwards.
- Threshold parameters outside 0..FIFO_SIZE are illegal. Simulation must report an error at elaboration.

Test Plan:
- FIFO_SIZE=8, W_WIDTH=8, FWFT=0: write 0x01..0x08 -> full=1 and level=8 after the 8th edge. A 9th write (0x09) -> overflow=1, level stays 8. Read 8 -> data_out 0x01..0x08, each with rd_valid 1 cycle after rd_en; empty=1 after the last read.
- Full FIFO, simultaneous wr_en (0xAA) and rd_en -> both accepted, level stays 8, full stays 1. After 8 more reads, the last word is 0xAA.
- Empty FIFO, simultaneous wr_en (0x55) and rd_en -> level=1, underflow=1, rd_valid=0. The next read returns 0x55.
- FIFO_SIZE=6 (non-power-of-2): push/pop 20 words continuously with 3 resident -> output order preserved across wrap, level constant at 3.
- FWFT=1: write 0x33 into an empty FIFO -> data_out=0x33 and rd_valid=1 one cycle later, with rd_en not asserted. Pulse rd_en -> empty=1.
- AF_THRESH=6, AE_THRESH=2, level=5 with overflow set. Assert flush together with wr_en -> level=0, overflow=0, empty=1, almost_empty=1. Assert rst mid-burst -> all outputs at reset values in the same cycle.
